regfile_write_arbiter: RTL
==========================

# regfile_write_arbiter

Write-port controller for the SIC-4 4x8 register file. It shares the single regfile write port between two requesters: A is ALU writeback, B is the load/IO path. It uses a valid/ready handshake with round-robin priority. After every reset it zero-fills all registers before accepting any requests. Its registered outputs drive the regfile's write enable, write address and write data directly; the regfile commits on the following negedge of `clk`.

## Interface
- `DATA_W`, 8, register data width
- `ADDR_W`, 2, register address width; `NREGS` = 2**`ADDR_W` = 4
- `clk`  in  1  system clock; all state updates on posedge
- `reset`  in  1  asynchronous, active-high reset
- `a_valid`  in  1  requester A has a write pending
- `a_addr`  in  `ADDR_W`  requester A destination register
- `a_data`  in  `DATA_W`  requester A write data
- `a_ready`  out  1  A accepted this cycle (combinational)
- `b_valid`, `b_addr`, `b_data`, `b_ready`: same as A, for requester B
- `rf_write`  out  1  to regfile write enable
- `rf_waddr`  out  `ADDR_W`  to regfile write-register select
- `rf_wdata`  out  `DATA_W`  to regfile write data
- `init_done`  out  1  high once the zero-fill sequence has completed

## Operation
- Reset values: `rf_write`=0, `rf_waddr`=0, `rf_wdata`=0, `init_done`=0, `a_ready`=`b_ready`=0. State resets to INIT, fill counter `cnt` to 0, and priority pointer `prio` to A.
- States:
  - INIT, zero-fill:
    - each posedge: `rf_write`<=1, `rf_waddr`<=`cnt`, `rf_wdata`<=0, `cnt`<=`cnt`+1.
    - when `cnt`==`NREGS`-1: state<=RUN and `init_done`<=1.
    - `a_ready`=`b_ready`=0 throughout.
  - RUN, arbitration:
    - `a_ready` = RUN & `a_valid` & (!`b_valid` | `prio`==A).
    - `b_ready` = RUN & `b_valid` & (!`a_valid` | `prio`==B).
    - At most one ready is asserted per cycle.
- Transfer: occurs when valid & ready at a posedge.
  - Outputs update: `rf_write`<=1, `rf_waddr`<=granted addr, `rf_wdata`<=granted data.
  - With no transfer: `rf_write`<=0; `rf_waddr` and `rf_wdata` hold their values.
- Priority pointer:
  - after a transfer from A, `prio`<=B; after a transfer from B, `prio`<=A.
  - `prio` is unchanged on idle cycles.
- Requester rules:
  - valid, addr and data stay stable from assertion until a ready is seen.
  - valid may drop only after the transfer.
  - The arbiter never drops or duplicates an accepted write.
- Writes to the same address are committed in acceptance order; no coalescing.
- `init_done` stays 1 until the next reset.
- Once RUN is entered, the block remains in RUN until reset.

## Timing
- Fill sequence, counting edges after reset deassertion:
  - edges 1-4 drive `rf_write`=1 with `rf_waddr` = 0, 1, 2, 3 and `rf_wdata` = 0x00.
  - each write commits on the negedge within its cycle.
  - `init_done` rises at edge 4.
- The first request can be accepted at edge 5.
- Latency:
  - a transfer at edge N presents the write on `rf_*` during cycle N..N+1.
  - the regfile commits it at the negedge inside that cycle.
  - a regfile read of that register returns the new value from that negedge on.
- Throughput: one write per cycle, sustained. Back-to-back transfers keep `rf_write` high continuously.
- Reset asserted mid-INIT or mid-RUN:
  - all outputs return to their reset values immediately, without waiting for `clk`.
  - a write present on `rf_*` at that moment is abandoned if the negedge has not yet occurred.
  - after release the fill sequence restarts from register 0.
- A request held across reset is accepted only after the new fill sequence completes.

## Test plan
- Reset then release → `rf_write`=1 for exactly 4 cycles with addr 0,1,2,3 and data 0x00; `init_done`=1 after edge 4; all regfile registers read 0x00; `a_ready`/`b_ready` stay 0 during fill.
- After fill, A only: `a_valid`, addr 2, data 0xA5 → `a_ready`=1 in the same cycle; next cycle `rf_write`=1, `rf_waddr`=2, `rf_wdata`=0xA5; reg2 reads 0xA5 after the negedge; `rf_write`=0 the cycle after.
- Contention: A (addr 1, 0x11) and B (addr 3, 0x33) both held valid for 4 cycles, with A re-presenting after each grant → grants go A, B, A, B; `rf_write` stays high for 4 consecutive cycles; reg1=0x11, reg3=0x33.
- Request during fill: `a_valid` (addr 0, 0x7E) asserted at reset release → `a_ready`=0 for edges 1-4, transfer at edge 5; reg0 ends as 0x7E, not 0x00.
- Same-address ordering: B writes addr 0 with 0x01, then immediately 0x02 → two consecutive `rf_write` cycles; reg0 ends as 0x02.
- Reset during the fill's second cycle, released mid-cycle → `rf_write` drops asynchronously; the sequence restarts with addr 0; `init_done` rises 4 edges after release.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the SIC-4 4x8 register file.
// Zero-fills every register after reset, then round-robins two requesters.
module regfile_write_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              init_done
);

    localparam int NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NREGS - 1);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic PRIO_A = 1'b0;
    localparam logic PRIO_B = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              prio_q, prio_d;
    logic              rf_write_q, rf_write_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              init_done_q, init_done_d;

    logic run;
    logic a_xfer;
    logic b_xfer;

    assign run = (state_q == ST_RUN);

    // Grant: a lone requester wins, contention goes to the priority holder
    always_comb begin
        a_ready = run & a_valid & (~b_valid | (prio_q == PRIO_A));
        b_ready = run & b_valid & (~a_valid | (prio_q == PRIO_B));
    end

    assign a_xfer = a_valid & a_ready;
    assign b_xfer = b_valid & b_ready;

    // Next-state: zero-fill sequencing in INIT, winner forwarding in RUN
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prio_d      = prio_q;
        rf_write_d  = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        init_done_d = init_done_q;
        case (state_q)
            ST_INIT: begin
                rf_write_d = 1'b1;
                rf_waddr_d = cnt_q;
                rf_wdata_d = '0;
                cnt_d      = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST_REG) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (a_xfer) begin
                    rf_write_d = 1'b1;
                    rf_waddr_d = a_addr;
                    rf_wdata_d = a_data;
                    prio_d     = PRIO_B;
                end else if (b_xfer) begin
                    rf_write_d = 1'b1;
                    rf_waddr_d = b_addr;
                    rf_wdata_d = b_data;
                    prio_d     = PRIO_A;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // State registers; reset abandons any write still on the port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            prio_q      <= PRIO_A;
            rf_write_q  <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prio_q      <= prio_d;
            rf_write_q  <= rf_write_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            init_done_q <= init_done_d;
        end
    end

    assign rf_write  = rf_write_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign init_done = init_done_q;

endmodule
